// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
// Shares the single MAC TX datapath between N_REQ ingress length FIFOs.
// A requester is picked round-robin, its frame length is popped and handed to the
// TX byte sequencer, and the grant is held until the sequencer reports completion.
// Lengths of zero or above MAX_LEN are popped and dropped without a tx_start.
//
// Build option: define TX_ARB_IFG_EN to insert an inter-frame gap of IFG_CYCLES
// clocks (GAP state, busy high, grant low) after every completed frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; scanning req_valid from rr_ptr
// LOAD  | pop strobe and grant out; length legality decided here
// START | tx_start pulse to the sequencer, grant held
// BUSY  | frame in flight, waiting for tx_done
// GAP   | inter-frame gap countdown (TX_ARB_IFG_EN builds only)

module tx_frame_arbiter #(
    parameter int N_REQ      = 2,
    parameter int LEN_W      = 16,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       req_pop,
    output logic [N_REQ-1:0]       grant,
    output logic                   tx_start,
    output logic [LEN_W-1:0]       tx_len,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [15:0]            drop_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2) begin : g_bad_n_req
        $error("tx_frame_arbiter: N_REQ must be at least 2");
    end
    if (IFG_CYCLES < 1) begin : g_bad_ifg
        $error("tx_frame_arbiter: IFG_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             sel_found;
    logic             len_ok;
    int               cand;
    logic [LEN_W-1:0] len_arr [N_REQ];

`ifdef TX_ARB_IFG_EN
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_found && req_valid[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign next_ptr = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // tx_len already holds the popped length while in LOAD, so legality is judged on it.
    assign len_ok = (tx_len != '0) && (tx_len <= LEN_W'(MAX_LEN));

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Arbitration FSM; every output is a register updated alongside the state.
    // rr_ptr is advanced on the IDLE->LOAD edge so it is already past the winner
    // during LOAD, which holds for both dropped and transmitted frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            req_pop  <= '0;
            grant    <= '0;
            tx_start <= 1'b0;
            tx_len   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
`ifdef TX_ARB_IFG_EN
            gap_cnt  <= '0;
`endif
        end else begin
            req_pop  <= '0;
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        state   <= S_LOAD;
                        tx_len  <= len_arr[sel_idx];
                        req_pop <= onehot(sel_idx);
                        grant   <= onehot(sel_idx);
                        rr_ptr  <= next_ptr;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!len_ok) begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end else begin
                        state    <= S_START;
                        tx_start <= 1'b1;
                    end
                end
                S_START: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (tx_done) begin
                        grant <= '0;
`ifdef TX_ARB_IFG_EN
                        state   <= S_GAP;
                        gap_cnt <= GAP_W'(IFG_CYCLES - 1);
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef TX_ARB_IFG_EN
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
